// File: rtl/spi_dev_cfg_seq_if.sv
// Bundle of control, table and SPI-master signals used by the config sequencer.
// The master modport is the sequencer's view; slave is the surrounding logic.
interface spi_dev_cfg_seq_if #(
    parameter int unsigned CMD_WIDTH = 24,
    parameter int unsigned RD_WIDTH  = 8,
    parameter int unsigned IDX_WIDTH = 4
);
    logic                 cfg_start;
    logic                 cfg_abort;
    logic [IDX_WIDTH-1:0] tbl_addr;
    logic [CMD_WIDTH-1:0] tbl_data;
    logic                 spi_wr_cmd;
    logic                 spi_rd_cmd;
    logic [CMD_WIDTH-1:0] spi_wr_data;
    logic                 spi_busy;
    logic                 spi_done;
    logic [RD_WIDTH-1:0]  spi_rd_data;
    logic                 cfg_busy;
    logic                 cfg_done;
    logic                 cfg_err;
    logic [2:0]           err_code;
    logic [IDX_WIDTH-1:0] err_idx;

    modport master (
        input  cfg_start, cfg_abort, tbl_data, spi_busy, spi_done, spi_rd_data,
        output tbl_addr, spi_wr_cmd, spi_rd_cmd, spi_wr_data,
               cfg_busy, cfg_done, cfg_err, err_code, err_idx
    );

    modport slave (
        output cfg_start, cfg_abort, tbl_data, spi_busy, spi_done, spi_rd_data,
        input  tbl_addr, spi_wr_cmd, spi_rd_cmd, spi_wr_data,
               cfg_busy, cfg_done, cfg_err, err_code, err_idx
    );
endinterface

// File: rtl/spi_dev_cfg_seq.sv
// Table-driven SPI register configuration sequencer: checks the device ID,
// writes NUM_REGS table words, reads each back, retries and reports errors.
module spi_dev_cfg_seq #(
    parameter int unsigned          CMD_WIDTH      = 24,
    parameter int unsigned          RD_WIDTH       = 8,
    parameter int unsigned          NUM_REGS       = 14,
    parameter int unsigned          IDX_WIDTH      = 4,
    parameter logic [CMD_WIDTH-1:0] ID_CMD         = 24'h808001,
    parameter logic [RD_WIDTH-1:0]  ID_VALUE       = 8'h6A,
    parameter bit                   VERIFY_EN      = 1'b1,
    parameter logic [7:0]           NOVERIFY_ADDR  = 8'hFF,
    parameter int unsigned          TIMEOUT_CYCLES = 65535,
    parameter int unsigned          MAX_RETRY      = 3
) (
    input logic               clk,
    input logic               rst,
    spi_dev_cfg_seq_if.master bus
);
    localparam int unsigned TMR_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RTY_WIDTH = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_WIDTH-1:0] RTY_LAST = RTY_WIDTH'(MAX_RETRY);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        IDLE, ID_RD, ID_WAIT, FETCH, LAT, WR_ISSUE, WR_WAIT,
        VF_ISSUE, VF_WAIT, NEXT, DONE, ERR
    } state_t;

    state_t               state_q, state_d;
    logic                 start_q;
    logic [IDX_WIDTH-1:0] idx_q;
    logic [RTY_WIDTH-1:0] retry_q;
    logic [TMR_WIDTH-1:0] timer_q;
    logic [CMD_WIDTH-1:0] entry_q;
    logic [2:0]           pend_code_q, pend_code_d;
    logic                 err_q;
    logic [2:0]           err_code_q;
    logic [IDX_WIDTH-1:0] err_idx_q;
    logic                 retry_inc;

    logic start_edge, wait_st, timeout, exhausted, abort_hit, issue, vf_needed, vf_match;

    assign start_edge = bus.cfg_start & ~start_q;
    assign wait_st    = state_q inside {ID_WAIT, WR_WAIT, VF_WAIT};
    assign timeout    = wait_st && !bus.spi_done && (timer_q == TMR_LAST);
    assign exhausted  = (retry_q == RTY_LAST);
    assign abort_hit  = bus.cfg_abort && (state_q != IDLE) && (state_q != ERR);
    assign issue      = (state_q inside {ID_RD, WR_ISSUE, VF_ISSUE}) && !bus.spi_busy && !abort_hit;
    assign vf_needed  = VERIFY_EN && (entry_q[15:8] != NOVERIFY_ADDR);
    assign vf_match   = (bus.spi_rd_data == entry_q[RD_WIDTH-1:0]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; abort overrides every other decision taken this cycle.
    always_comb begin
        state_d     = state_q;
        retry_inc   = 1'b0;
        pend_code_d = 3'd0;
        unique case (state_q)
            IDLE:    if (start_edge) state_d = ID_RD;
            ID_RD:   if (issue) state_d = ID_WAIT;
            ID_WAIT: begin
                if (bus.spi_done) begin
                    if (bus.spi_rd_data == ID_VALUE) state_d = FETCH;
                    else if (exhausted) begin state_d = ERR; pend_code_d = 3'd1; end
                    else begin state_d = ID_RD; retry_inc = 1'b1; end
                end else if (timeout) begin
                    if (exhausted) begin state_d = ERR; pend_code_d = 3'd2; end
                    else begin state_d = ID_RD; retry_inc = 1'b1; end
                end
            end
            FETCH:    state_d = LAT;
            LAT:      state_d = WR_ISSUE;
            WR_ISSUE: if (issue) state_d = WR_WAIT;
            WR_WAIT: begin
                if (bus.spi_done) state_d = vf_needed ? VF_ISSUE : NEXT;
                else if (timeout) begin
                    if (exhausted) begin state_d = ERR; pend_code_d = 3'd2; end
                    else begin state_d = WR_ISSUE; retry_inc = 1'b1; end
                end
            end
            VF_ISSUE: if (issue) state_d = VF_WAIT;
            VF_WAIT: begin
                if (bus.spi_done) begin
                    if (vf_match) state_d = NEXT;
                    else if (exhausted) begin state_d = ERR; pend_code_d = 3'd3; end
                    else begin state_d = WR_ISSUE; retry_inc = 1'b1; end
                end else if (timeout) begin
                    // A lost readback is retried as a readback, not a rewrite.
                    if (exhausted) begin state_d = ERR; pend_code_d = 3'd2; end
                    else begin state_d = VF_ISSUE; retry_inc = 1'b1; end
                end
            end
            NEXT:    state_d = (idx_q == IDX_LAST) ? DONE : FETCH;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_hit) begin
            state_d     = ERR;
            pend_code_d = 3'd4;
            retry_inc   = 1'b0;
        end
    end

    // Datapath: start sampling, index, retry counter, timer, entry and error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Sampling start during reset keeps a level held across reset from
            // looking like a fresh edge afterwards.
            start_q     <= bus.cfg_start;
            idx_q       <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            entry_q     <= '0;
            pend_code_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            err_idx_q   <= '0;
        end else begin
            start_q <= bus.cfg_start;
            if (state_q == IDLE && start_edge) begin
                idx_q      <= '0;
                retry_q    <= '0;
                err_q      <= 1'b0;
                err_code_q <= '0;
                err_idx_q  <= '0;
            end
            if (issue) timer_q <= '0;
            else if (wait_st && timer_q != TMR_LAST) timer_q <= timer_q + 1'b1;
            if (retry_inc) retry_q <= retry_q + 1'b1;
            if (state_q == NEXT) begin
                retry_q <= '0;
                if (idx_q != IDX_LAST) idx_q <= idx_q + 1'b1;
            end
            if (state_q == LAT) entry_q <= bus.tbl_data;
            if (state_d == ERR && state_q != ERR) pend_code_q <= pend_code_d;
            if (state_q == ERR) begin
                err_q      <= 1'b1;
                err_code_q <= pend_code_q;
                err_idx_q  <= idx_q;
            end
        end
    end

    // Outputs: single-cycle requests with their command word, status flags.
    always_comb begin
        bus.spi_wr_cmd  = 1'b0;
        bus.spi_rd_cmd  = 1'b0;
        bus.spi_wr_data = '0;
        if (issue) begin
            unique case (state_q)
                ID_RD: begin
                    bus.spi_rd_cmd  = 1'b1;
                    bus.spi_wr_data = ID_CMD;
                end
                WR_ISSUE: begin
                    bus.spi_wr_cmd  = 1'b1;
                    bus.spi_wr_data = entry_q;
                end
                VF_ISSUE: begin
                    bus.spi_rd_cmd  = 1'b1;
                    bus.spi_wr_data = {1'b1, entry_q[CMD_WIDTH-2:RD_WIDTH], {RD_WIDTH{1'b0}}};
                end
                default: ;
            endcase
        end
        bus.tbl_addr = idx_q;
        bus.cfg_busy = (state_q != IDLE);
        bus.cfg_done = (state_q == DONE) && !abort_hit;
        bus.cfg_err  = err_q;
        bus.err_code = err_code_q;
        bus.err_idx  = err_idx_q;
    end
endmodule
